// File: rtl/pc_fetch_stage.sv
// Instruction fetch: PC register, PC-source mux select, reset/interrupt vector sequencing, IF/ID register.
// Fetch-to-IF/ID takes 1 cycle. Stall holds the PC and IF/ID. Flush squashes IF/ID. Vector loads take VEC_LAT cycles.
module pc_fetch_stage #(
  parameter int VEC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] next_pc,
  input  logic [1:0] pc_src_dp,
  input  logic       stall,
  input  logic       flush,
  input  logic       intr,
  input  logic [7:0] imem_data,
  output logic [7:0] pc,
  output logic [7:0] pc_plus_1,
  output logic [1:0] pc_sel,
  output logic       vec_sel,
  output logic [7:0] if_id_instr,
  output logic [7:0] if_id_pc1,
  output logic       if_id_valid,
  output logic       int_ack,
  output logic [7:0] ret_pc
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    INTV = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] pc1;
    logic       valid;
  } if_id_t;

  localparam logic [1:0] WCNT_RELOAD = 2'(VEC_LAT - 1);
  localparam if_id_t     IF_ID_BUBBLE = '{instr: 8'h00, pc1: 8'h00, valid: 1'b0};

  state_t     state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [7:0] pc_q, pc_d;
  if_id_t     if_id_q, if_id_d;
  logic       int_ack_q, int_ack_d;
  logic [7:0] ret_pc_q, ret_pc_d;

  assign pc_plus_1 = pc_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pc_d      = pc_q;
    if_id_d   = if_id_q;
    int_ack_d = 1'b0;
    ret_pc_d  = ret_pc_q;
    pc_sel    = 2'b11;
    vec_sel   = 1'b0;

    unique case (state_q)
      BOOT, INTV: begin
        // Vector read in flight: decode sees bubbles, all pipeline controls ignored.
        vec_sel = (state_q == INTV);
        if_id_d = IF_ID_BUBBLE;
        if (wcnt_q == 2'd0) begin
          pc_d    = next_pc;
          wcnt_d  = WCNT_RELOAD;
          state_d = RUN;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      RUN: begin
        pc_sel = pc_src_dp;
        if (flush) begin
          pc_d    = next_pc;
          if_id_d = IF_ID_BUBBLE;
        end else if (stall) begin
          pc_d    = pc_q;
        end else if (intr && (pc_src_dp == 2'b00)) begin
          // Only taken on a sequential fetch so the return address is unambiguous.
          ret_pc_d  = pc_q;
          int_ack_d = 1'b1;
          if_id_d   = IF_ID_BUBBLE;
          state_d   = INTV;
        end else begin
          pc_d    = next_pc;
          if_id_d = '{instr: imem_data, pc1: pc_plus_1, valid: 1'b1};
        end
      end
      default: begin
        state_d = BOOT;
        wcnt_d  = WCNT_RELOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      wcnt_q    <= WCNT_RELOAD;
      pc_q      <= 8'h00;
      if_id_q   <= IF_ID_BUBBLE;
      int_ack_q <= 1'b0;
      ret_pc_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      pc_q      <= pc_d;
      if_id_q   <= if_id_d;
      int_ack_q <= int_ack_d;
      ret_pc_q  <= ret_pc_d;
    end
  end

  assign pc          = pc_q;
  assign if_id_instr = if_id_q.instr;
  assign if_id_pc1   = if_id_q.pc1;
  assign if_id_valid = if_id_q.valid;
  assign int_ack     = int_ack_q;
  assign ret_pc      = ret_pc_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage with VEC_LAT=2: boot, wrap, stall/flush, deferred interrupt, reset during INTV.
module tb_pc_fetch_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] next_pc;
  logic [1:0] pc_src_dp;
  logic       stall;
  logic       flush;
  logic       intr;
  logic [7:0] imem_data;
  logic [7:0] pc;
  logic [7:0] pc_plus_1;
  logic [1:0] pc_sel;
  logic       vec_sel;
  logic [7:0] if_id_instr;
  logic [7:0] if_id_pc1;
  logic       if_id_valid;
  logic       int_ack;
  logic [7:0] ret_pc;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_stage #(.VEC_LAT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .pc_src_dp  (pc_src_dp),
    .stall      (stall),
    .flush      (flush),
    .intr       (intr),
    .imem_data  (imem_data),
    .pc         (pc),
    .pc_plus_1  (pc_plus_1),
    .pc_sel     (pc_sel),
    .vec_sel    (vec_sel),
    .if_id_instr(if_id_instr),
    .if_id_pc1  (if_id_pc1),
    .if_id_valid(if_id_valid),
    .int_ack    (int_ack),
    .ret_pc     (ret_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; next_pc = 8'h00; pc_src_dp = 2'b00; stall = 1'b0;
    flush = 1'b0; intr = 1'b0; imem_data = 8'h00;
    step();
    step();
    chk("rst_pc", pc, 8'h00);
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_instr", if_id_instr, 8'h00);
    chk("rst_pc1", if_id_pc1, 8'h00);
    chk("rst_ack", int_ack, 1'b0);
    chk("rst_retpc", ret_pc, 8'h00);
    chk("rst_pcsel", pc_sel, 2'b11);
    chk("rst_vecsel", vec_sel, 1'b0);

    // Boot from M[0]=0x40; pc_src_dp nonzero must be ignored while booting.
    rst = 1'b0; next_pc = 8'h40; pc_src_dp = 2'b01; imem_data = 8'hEE;
    #2;
    chk("boot0_pcsel", pc_sel, 2'b11);
    step();
    chk("boot1_pc", pc, 8'h00);
    chk("boot1_pcsel", pc_sel, 2'b11);
    chk("boot1_vecsel", vec_sel, 1'b0);
    chk("boot1_valid", if_id_valid, 1'b0);
    pc_src_dp = 2'b00;
    step();
    chk("boot2_pc", pc, 8'h40);
    chk("boot2_pcsel", pc_sel, 2'b00);
    chk("boot2_valid", if_id_valid, 1'b0);
    chk("boot2_pcp1", pc_plus_1, 8'h41);
    next_pc = 8'h41; imem_data = 8'hA5;
    step();
    chk("boot3_valid", if_id_valid, 1'b1);
    chk("boot3_pc1", if_id_pc1, 8'h41);
    chk("boot3_instr", if_id_instr, 8'hA5);
    chk("boot3_pc", pc, 8'h41);

    // Jump to 0xFE via flush, then run sequentially through the wrap.
    flush = 1'b1; next_pc = 8'hFE;
    step();
    flush = 1'b0;
    chk("fl_pc", pc, 8'hFE);
    chk("fl_valid", if_id_valid, 1'b0);
    next_pc = 8'hFF; imem_data = 8'h11;
    step();
    chk("wrap1_pc", pc, 8'hFF);
    chk("wrap1_pc1", if_id_pc1, 8'hFF);
    chk("wrap1_instr", if_id_instr, 8'h11);
    chk("wrap1_pcp1", pc_plus_1, 8'h00);
    next_pc = 8'h00; imem_data = 8'h22;
    step();
    chk("wrap2_pc", pc, 8'h00);
    chk("wrap2_pc1", if_id_pc1, 8'h00);
    chk("wrap2_valid", if_id_valid, 1'b1);
    chk("wrap2_pcp1", pc_plus_1, 8'h01);

    // Stall three cycles with intr pending (deferred), then flush while still stalled.
    stall = 1'b1; intr = 1'b1; next_pc = 8'h55; imem_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 8'h00);
      chk("stall_pc1", if_id_pc1, 8'h00);
      chk("stall_instr", if_id_instr, 8'h22);
      chk("stall_valid", if_id_valid, 1'b1);
      chk("stall_ack", int_ack, 1'b0);
    end
    intr = 1'b0; flush = 1'b1; next_pc = 8'h20;
    step();
    stall = 1'b0; flush = 1'b0;
    chk("sfl_pc", pc, 8'h20);
    chk("sfl_valid", if_id_valid, 1'b0);
    chk("sfl_instr", if_id_instr, 8'h00);

    // intr while pc_src_dp=01 is deferred; accepted on the next sequential cycle.
    intr = 1'b1; pc_src_dp = 2'b01; next_pc = 8'h33; imem_data = 8'h5A;
    #1;
    chk("def_pcsel", pc_sel, 2'b01);
    step();
    chk("def_pc", pc, 8'h33);
    chk("def_ack", int_ack, 1'b0);
    chk("def_valid", if_id_valid, 1'b1);
    chk("def_pc1", if_id_pc1, 8'h21);
    chk("def_instr", if_id_instr, 8'h5A);
    pc_src_dp = 2'b00; next_pc = 8'h34;
    step();
    intr = 1'b0;
    chk("acc_ack", int_ack, 1'b1);
    chk("acc_retpc", ret_pc, 8'h33);
    chk("acc_pc", pc, 8'h33);
    chk("acc_valid", if_id_valid, 1'b0);
    chk("acc_pcsel", pc_sel, 2'b11);
    chk("acc_vecsel", vec_sel, 1'b1);
    next_pc = 8'h80;
    step();
    chk("intv1_ack", int_ack, 1'b0);
    chk("intv1_pc", pc, 8'h33);
    chk("intv1_vecsel", vec_sel, 1'b1);
    step();
    chk("intv2_pc", pc, 8'h80);
    chk("intv2_vecsel", vec_sel, 1'b0);
    chk("intv2_valid", if_id_valid, 1'b0);
    next_pc = 8'h81; imem_data = 8'hC3;
    step();
    chk("isr_valid", if_id_valid, 1'b1);
    chk("isr_pc1", if_id_pc1, 8'h81);
    chk("isr_instr", if_id_instr, 8'hC3);
    chk("isr_retpc", ret_pc, 8'h33);

    // Second interrupt, then async reset in the middle of INTV.
    intr = 1'b1;
    step();
    intr = 1'b0;
    chk("acc2_ack", int_ack, 1'b1);
    chk("acc2_retpc", ret_pc, 8'h81);
    chk("acc2_vecsel", vec_sel, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_ack", int_ack, 1'b0);
    chk("mrst_vecsel", vec_sel, 1'b0);
    chk("mrst_pc", pc, 8'h00);
    chk("mrst_retpc", ret_pc, 8'h00);
    chk("mrst_pcsel", pc_sel, 2'b11);
    step();
    rst = 1'b0; next_pc = 8'h40; imem_data = 8'h6B;
    step();
    chk("reboot1_pc", pc, 8'h00);
    chk("reboot1_vecsel", vec_sel, 1'b0);
    step();
    chk("reboot2_pc", pc, 8'h40);
    next_pc = 8'h41;
    step();
    chk("reboot3_valid", if_id_valid, 1'b1);
    chk("reboot3_pc1", if_id_pc1, 8'h41);
    chk("reboot3_instr", if_id_instr, 8'h6B);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
